// File: rtl/loadstore_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and lane geometry.
package loadstore_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_ISSUE   = 3'd1;
    localparam state_t ST_MERGE   = 3'd2;
    localparam state_t ST_CAPTURE = 3'd3;
    localparam state_t ST_RESP    = 3'd4;

    localparam int BYTE_BITS = 8;
    localparam int HALF_BITS = 16;

    // Reserved size 11 is folded onto word so the rest of the unit sees three sizes only.
    function automatic logic [1:0] norm_size(input logic [1:0] size);
        return (size == SZ_RSVD) ? SZ_WORD : size;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        return ((size == SZ_HALF) && offset[0]) || ((size == SZ_WORD) && (offset != 2'b00));
    endfunction

endpackage

// File: rtl/loadstore_lane_align.sv
// Combinational lane steering: merges store data into an old word and extracts/extends load data.
module loadstore_lane_align
    import loadstore_pkg::*;
(
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    output logic [31:0] merged,
    output logic [31:0] load_val
);

    logic [BYTE_BITS-1:0] byte_lane;
    logic [HALF_BITS-1:0] half_lane;

    // Halfwords are selected by offset[1] only; offset[0] is already rejected as misaligned.
    assign byte_lane = old_word[{offset, 3'b000} +: BYTE_BITS];
    assign half_lane = old_word[{offset[1], 4'b0000} +: HALF_BITS];

    always_comb begin
        merged   = old_word;
        load_val = old_word;
        case (size)
            SZ_BYTE: begin
                merged[{offset, 3'b000} +: BYTE_BITS] = wdata[BYTE_BITS-1:0];
                load_val = {{24{sign_ext & byte_lane[BYTE_BITS-1]}}, byte_lane};
            end
            SZ_HALF: begin
                merged[{offset[1], 4'b0000} +: HALF_BITS] = wdata[HALF_BITS-1:0];
                load_val = {{16{sign_ext & half_lane[HALF_BITS-1]}}, half_lane};
            end
            default: begin
                merged   = wdata;
                load_val = old_word;
            end
        endcase
    end

endmodule

// File: rtl/loadstore_unit.sv
// Memory-stage load/store unit: turns byte/half/word requests into word cycles on a
// synchronous-read data memory, using read-modify-write for sub-word stores.
module loadstore_unit
    import loadstore_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [31:0]           req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_misaligned,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_dataIn,
    input  logic [DATA_WIDTH-1:0] mem_dataOut
);

    state_t                  state;
    logic                    lat_store;
    logic [1:0]              lat_size;
    logic                    lat_signed;
    logic [1:0]              lat_off;
    logic [ADDR_WIDTH-1:0]   lat_waddr;
    logic [DATA_WIDTH-1:0]   lat_wdata;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    mis_q;

    logic [1:0]              in_size;
    logic                    in_misaligned;
    logic [DATA_WIDTH-1:0]   merged;
    logic [DATA_WIDTH-1:0]   load_val;
    logic                    unused_addr_hi;

    // High address bits beyond the memory are dropped, so accesses wrap around.
    assign unused_addr_hi = ^req_addr[31:ADDR_WIDTH+2];

    assign in_size       = norm_size(req_size);
    assign in_misaligned = is_misaligned(in_size, req_addr[1:0]);

    loadstore_lane_align u_align (
        .offset   (lat_off),
        .size     (lat_size),
        .sign_ext (lat_signed),
        .old_word (mem_dataOut),
        .wdata    (lat_wdata),
        .merged   (merged),
        .load_val (load_val)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            lat_store  <= 1'b0;
            lat_size   <= SZ_BYTE;
            lat_signed <= 1'b0;
            lat_off    <= 2'b00;
            lat_waddr  <= '0;
            lat_wdata  <= '0;
            rdata_q    <= '0;
            mis_q      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        lat_store  <= req_we;
                        lat_size   <= in_size;
                        lat_signed <= req_signed;
                        lat_off    <= req_addr[1:0];
                        lat_waddr  <= req_addr[ADDR_WIDTH+1:2];
                        lat_wdata  <= req_wdata;
                        rdata_q    <= '0;
                        mis_q      <= in_misaligned;
                        state      <= in_misaligned ? ST_RESP : ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (lat_store)
                        state <= (lat_size == SZ_WORD) ? ST_RESP : ST_MERGE;
                    else
                        state <= ST_CAPTURE;
                end
                ST_MERGE:   state <= ST_RESP;
                ST_CAPTURE: begin
                    rdata_q <= load_val;
                    state   <= ST_RESP;
                end
                ST_RESP:    state <= ST_IDLE;
                default:    state <= ST_IDLE;
            endcase
        end
    end

    // Memory drive decodes straight from state so an async reset kills mem_we at once.
    always_comb begin
        mem_address = '0;
        mem_we      = 1'b0;
        mem_dataIn  = '0;
        case (state)
            ST_ISSUE: begin
                mem_address = lat_waddr;
                if (lat_store && (lat_size == SZ_WORD)) begin
                    mem_we     = 1'b1;
                    mem_dataIn = lat_wdata;
                end
            end
            ST_MERGE: begin
                mem_address = lat_waddr;
                mem_we      = 1'b1;
                mem_dataIn  = merged;
            end
            ST_CAPTURE: mem_address = lat_waddr;
            default: ;
        endcase
    end

    assign req_ready       = (state == ST_IDLE);
    assign resp_valid      = (state == ST_RESP);
    assign resp_rdata      = rdata_q;
    assign resp_misaligned = mis_q;

endmodule

// File: tb/tb_loadstore_unit.sv
// Self-checking bench for loadstore_unit with a behavioural synchronous-read data memory.
module tb_loadstore_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_misaligned;
    logic [9:0]  mem_address;
    logic        mem_we;
    logic [31:0] mem_dataIn;
    logic [31:0] mem_dataOut;

    logic [31:0] mem [1024];
    logic        mem_clear;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
        int          lat;
        int          wes;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    loadstore_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_we          (req_we),
        .req_size        (req_size),
        .req_signed      (req_signed),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .resp_valid      (resp_valid),
        .resp_rdata      (resp_rdata),
        .resp_misaligned (resp_misaligned),
        .mem_address     (mem_address),
        .mem_we          (mem_we),
        .mem_dataIn      (mem_dataIn),
        .mem_dataOut     (mem_dataOut)
    );

    // Word 2 is preloaded with a marker so the aborted store can be seen not to land.
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
            mem[2] <= 32'hCAFEF00D;
        end else if (mem_we) begin
            mem[mem_address] <= mem_dataIn;
        end
        mem_dataOut <= mem[mem_address];
    end

    // Drives one request, scrambles the inputs after acceptance, and waits a bounded time for the response.
    task automatic run_req(input logic we, input logic [1:0] size, input logic sgn,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output logic [31:0] rdata, output logic mis,
                           output int lat, output int wes, output logic ready_seen);
        @(negedge clk);
        ready_seen = req_ready;
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_we     = ~we;
        req_size   = 2'($urandom);
        req_signed = ~sgn;
        req_addr   = $urandom;
        req_wdata  = $urandom;
        rdata = 32'h0;
        mis   = 1'b0;
        lat   = 0;
        wes   = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (mem_we) wes++;
            if (resp_valid) begin
                lat   = c;
                rdata = resp_rdata;
                mis   = resp_misaligned;
                break;
            end
        end
    endtask

    task automatic test_reset();
        n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b, want 1", req_ready); end
        n_cmp++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %b, want 0", resp_valid); end
        n_cmp++; if (resp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h, want 0", resp_rdata); end
        n_cmp++; if (resp_misaligned !== 1'b0) begin n_fail++; $display("FAIL reset_mis: got %b, want 0", resp_misaligned); end
        n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %b, want 0", mem_we); end
        n_cmp++; if (mem_address !== 10'h0) begin n_fail++; $display("FAIL reset_mem_address: got %h, want 0", mem_address); end
        n_cmp++; if (mem_dataIn !== 32'h0) begin n_fail++; $display("FAIL reset_mem_dataIn: got %h, want 0", mem_dataIn); end
    endtask

    task automatic test_word_store();
        logic [31:0] rd;
        logic        mis, rdy;
        int          lat, wes;
        exp_t        e;
        sb.push_back('{rdata: 32'h0, mis: 1'b0, lat: 2, wes: 1});
        run_req(1'b1, 2'b10, 1'b0, 32'h4, 32'h88776655, rd, mis, lat, wes, rdy);
        e = sb.pop_front();
        n_cmp++; if (lat !== e.lat) begin n_fail++; $display("FAIL sw_latency: got %0d, want %0d", lat, e.lat); end
        n_cmp++; if (wes !== e.wes) begin n_fail++; $display("FAIL sw_we_pulses: got %0d, want %0d", wes, e.wes); end
        n_cmp++; if (mis !== e.mis) begin n_fail++; $display("FAIL sw_misaligned: got %b, want %b", mis, e.mis); end
        n_cmp++; if (rd !== e.rdata) begin n_fail++; $display("FAIL sw_rdata: got %h, want %h", rd, e.rdata); end
        n_cmp++; if (mem[1] !== 32'h88776655) begin n_fail++; $display("FAIL sw_word1: got %h, want 88776655", mem[1]); end
    endtask

    task automatic test_loads();
        logic [31:0] addrs [5] = '{32'h7, 32'h7, 32'h6, 32'h4, 32'h4};
        logic [1:0]  sizes [5] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b11};
        logic        sgns  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] exps  [5] = '{32'hFFFFFF88, 32'h00000088, 32'hFFFF8877, 32'h00006655, 32'h88776655};
        logic [31:0] rd;
        logic        mis, rdy;
        int          lat, wes;
        exp_t        e;
        for (int i = 0; i < 5; i++) begin
            sb.push_back('{rdata: exps[i], mis: 1'b0, lat: 3, wes: 0});
            run_req(1'b0, sizes[i], sgns[i], addrs[i], 32'h0, rd, mis, lat, wes, rdy);
            e = sb.pop_front();
            n_cmp++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL load%0d_ready_b2b: got %b, want 1", i, rdy); end
            n_cmp++; if (lat !== e.lat) begin n_fail++; $display("FAIL load%0d_latency: got %0d, want %0d", i, lat, e.lat); end
            n_cmp++; if (wes !== e.wes) begin n_fail++; $display("FAIL load%0d_we_pulses: got %0d, want %0d", i, wes, e.wes); end
            n_cmp++; if (rd !== e.rdata) begin n_fail++; $display("FAIL load%0d_rdata: got %h, want %h", i, rd, e.rdata); end
        end
    endtask

    task automatic test_subword_store();
        logic [31:0] rd;
        logic        mis, rdy;
        int          lat, wes;
        exp_t        e;
        sb.push_back('{rdata: 32'h0, mis: 1'b0, lat: 3, wes: 1});
        run_req(1'b1, 2'b00, 1'b0, 32'h5, 32'h000000AB, rd, mis, lat, wes, rdy);
        e = sb.pop_front();
        n_cmp++; if (lat !== e.lat) begin n_fail++; $display("FAIL sb_latency: got %0d, want %0d", lat, e.lat); end
        n_cmp++; if (wes !== e.wes) begin n_fail++; $display("FAIL sb_we_pulses: got %0d, want %0d", wes, e.wes); end
        n_cmp++; if (rd !== e.rdata) begin n_fail++; $display("FAIL sb_rdata: got %h, want %h", rd, e.rdata); end
        n_cmp++; if (mem[1] !== 32'h8877AB55) begin n_fail++; $display("FAIL sb_word1: got %h, want 8877ab55", mem[1]); end
        sb.push_back('{rdata: 32'h8877AB55, mis: 1'b0, lat: 3, wes: 0});
        run_req(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, rd, mis, lat, wes, rdy);
        e = sb.pop_front();
        n_cmp++; if (rd !== e.rdata) begin n_fail++; $display("FAIL lw_after_sb_rdata: got %h, want %h", rd, e.rdata); end
        n_cmp++; if (lat !== e.lat) begin n_fail++; $display("FAIL lw_after_sb_latency: got %0d, want %0d", lat, e.lat); end
    endtask

    task automatic test_misaligned();
        logic        wes_in  [2] = '{1'b0, 1'b1};
        logic [1:0]  sizes   [2] = '{2'b10, 2'b01};
        logic [31:0] addrs   [2] = '{32'h6, 32'h3};
        logic [31:0] rd;
        logic        mis, rdy;
        int          lat, wes;
        exp_t        e;
        for (int i = 0; i < 2; i++) begin
            sb.push_back('{rdata: 32'h0, mis: 1'b1, lat: 1, wes: 0});
            run_req(wes_in[i], sizes[i], 1'b1, addrs[i], 32'hDEADBEEF, rd, mis, lat, wes, rdy);
            e = sb.pop_front();
            n_cmp++; if (mis !== e.mis) begin n_fail++; $display("FAIL mis%0d_flag: got %b, want %b", i, mis, e.mis); end
            n_cmp++; if (rd !== e.rdata) begin n_fail++; $display("FAIL mis%0d_rdata: got %h, want %h", i, rd, e.rdata); end
            n_cmp++; if (lat !== e.lat) begin n_fail++; $display("FAIL mis%0d_latency: got %0d, want %0d", i, lat, e.lat); end
            n_cmp++; if (wes !== e.wes) begin n_fail++; $display("FAIL mis%0d_we_pulses: got %0d, want %0d", i, wes, e.wes); end
        end
        n_cmp++; if (mem[1] !== 32'h8877AB55) begin n_fail++; $display("FAIL mis_word1_kept: got %h, want 8877ab55", mem[1]); end
    endtask

    task automatic test_reset_mid_op();
        int seen_resp = 0;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_size   = 2'b01;
        req_signed = 1'b0;
        req_addr   = 32'h8;
        req_wdata  = 32'h00001234;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL abort_in_merge_we: got %b, want 1", mem_we); end
        rst = 1'b1;
        #1;
        n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL abort_we_async: got %b, want 0", mem_we); end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (resp_valid) seen_resp++;
        end
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (resp_valid) seen_resp++;
        end
        n_cmp++; if (seen_resp !== 0) begin n_fail++; $display("FAIL abort_no_resp: got %0d pulses, want 0", seen_resp); end
        n_cmp++; if (mem[2] !== 32'hCAFEF00D) begin n_fail++; $display("FAIL abort_word2: got %h, want cafef00d", mem[2]); end
        n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL abort_ready_after: got %b, want 1", req_ready); end
    endtask

    task automatic test_wrap_and_upper_lanes();
        logic [31:0] rd;
        logic        mis, rdy;
        int          lat, wes;
        exp_t        e;
        sb.push_back('{rdata: 32'h8877AB55, mis: 1'b0, lat: 3, wes: 0});
        run_req(1'b0, 2'b10, 1'b0, 32'h1004, 32'h0, rd, mis, lat, wes, rdy);
        e = sb.pop_front();
        n_cmp++; if (rd !== e.rdata) begin n_fail++; $display("FAIL wrap_rdata: got %h, want %h", rd, e.rdata); end
        sb.push_back('{rdata: 32'h0, mis: 1'b0, lat: 3, wes: 1});
        run_req(1'b1, 2'b01, 1'b1, 32'hA, 32'hFFFF1234, rd, mis, lat, wes, rdy);
        e = sb.pop_front();
        n_cmp++; if (lat !== e.lat) begin n_fail++; $display("FAIL sh_hi_latency: got %0d, want %0d", lat, e.lat); end
        n_cmp++; if (wes !== e.wes) begin n_fail++; $display("FAIL sh_hi_we_pulses: got %0d, want %0d", wes, e.wes); end
        n_cmp++; if (mem[2] !== 32'h1234F00D) begin n_fail++; $display("FAIL sh_hi_word2: got %h, want 1234f00d", mem[2]); end
        sb.push_back('{rdata: 32'h00001234, mis: 1'b0, lat: 3, wes: 0});
        run_req(1'b0, 2'b01, 1'b1, 32'hA, 32'h0, rd, mis, lat, wes, rdy);
        e = sb.pop_front();
        n_cmp++; if (rd !== e.rdata) begin n_fail++; $display("FAIL lh_hi_rdata: got %h, want %h", rd, e.rdata); end
        sb.push_back('{rdata: 32'hFFFFFFF0, mis: 1'b0, lat: 3, wes: 0});
        run_req(1'b0, 2'b00, 1'b1, 32'h9, 32'h0, rd, mis, lat, wes, rdy);
        e = sb.pop_front();
        n_cmp++; if (rd !== e.rdata) begin n_fail++; $display("FAIL lb_off1_rdata: got %h, want %h", rd, e.rdata); end
        sb.push_back('{rdata: 32'h00000012, mis: 1'b0, lat: 3, wes: 0});
        run_req(1'b0, 2'b00, 1'b0, 32'hB, 32'h0, rd, mis, lat, wes, rdy);
        e = sb.pop_front();
        n_cmp++; if (rd !== e.rdata) begin n_fail++; $display("FAIL lbu_off3_rdata: got %h, want %h", rd, e.rdata); end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        mem_clear  = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        repeat (2) @(negedge clk);
        mem_clear = 1'b0;
        test_reset();
        @(negedge clk);
        rst = 1'b0;
        test_word_store();
        test_loads();
        test_subword_store();
        test_misaligned();
        test_reset_mid_op();
        test_wrap_and_upper_lanes();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/loadstore_unit.md
Name: loadstore_unit

Overview:
- Memory-stage access unit between the MIPS execute stage and the word-organised data memory (ADDR_WIDTH-bit word address, 32-bit dataIn/dataOut, single we, clk).
- Converts byte/halfword/word load and store requests into word-level memory cycles.
- Sub-word stores use read-modify-write; loads are sign/zero-extended.
- Uses a valid/ready request interface and a one-cycle response pulse.

Parameters:
DATA_WIDTH, 32, memory word width (fixed at 32; other values unsupported)
ADDR_WIDTH, 10, data memory word-address width

Ports:
clk  in  1  clock, rising-edge
rst  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  unit idle, request accepted on clk edge when req_valid & req_ready
req_we  in  1  1=store, 0=load
req_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
req_signed  in  1  loads: 1 sign-extend, 0 zero-extend; ignored for stores
req_addr  in  32  byte address
req_wdata  in  32  store data, right-justified
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  load result, valid with resp_valid; 0 for stores/misaligned
resp_misaligned  out  1  valid with resp_valid; access rejected
mem_address  out  ADDR_WIDTH  to datamemory address
mem_we  out  1  to datamemory we
mem_dataIn  out  32  to datamemory dataIn
mem_dataOut  in  32  from datamemory dataOut, valid one cycle after mem_address (synchronous read)

Behaviour:
- Reset (async, while rst=1): state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_misaligned=0, mem_we=0, mem_address=0, mem_dataIn=0.
- Lanes little-endian: byte offset k = bits 8k+7:8k; halfword offset 0 = bits 15:0, offset 2 = bits 31:16.
- Word address = req_addr[ADDR_WIDTH+1:2]; bits above ADDR_WIDTH+1 are ignored, so addresses wrap modulo 4*2^ADDR_WIDTH.
- Request fields are latched on acceptance; inputs may change afterwards.
- Misaligned:
  - half with addr[0]=1, word with addr[1:0]!=0.
  - IDLE -> RESP directly, no memory access, mem_we stays 0.
- States: IDLE, ISSUE, MERGE, CAPTURE, RESP.
- IDLE: req_ready=1. On acceptance go to ISSUE (or RESP if misaligned).
- ISSUE: mem_address = latched word address.
  - Word store: mem_we=1, mem_dataIn=wdata -> RESP.
  - Sub-word store: mem_we=0 (read) -> MERGE.
  - Load: mem_we=0 -> CAPTURE.
- MERGE:
  - mem_dataIn = mem_dataOut with the addressed byte/half lanes replaced by wdata[7:0]/[15:0].
  - mem_we=1 -> RESP.
- CAPTURE:
  - Extract the addressed lane from mem_dataOut, extend per req_signed into the result register -> RESP.
  - Word loads pass through unchanged.
- RESP: resp_valid=1 for exactly this cycle, with resp_rdata/resp_misaligned -> IDLE.
- req_ready=0 in every state except IDLE. Back-to-back requests are accepted in the cycle after RESP.
- Latency in cycles from the acceptance edge to the resp_valid cycle:
  - misaligned 1
  - word store 2
  - load 3
  - sub-word store 3
- mem_we is high for exactly one cycle per store and never for loads or misaligned accesses.
- Reset asserted mid-operation aborts immediately: mem_we drops asynchronously, no pending write completes, no resp_valid.
- Reserved req_size=11 behaves identically to 10.

Decomposition:
- Package loadstore_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD
  - FSM state enum
  - lane-select constants
- One combinational sub-module, loadstore_lane_align:
  - inputs: offset, size, signed, old word, wdata
  - outputs: merged store word, extended load value
  - instantiated once; FSM and registers stay in the top.

Test Plan:
- sw 0x88776655 to addr 0x4 -> mem_we single pulse, word 1 = 0x88776655, resp_valid 2 cycles after acceptance, resp_misaligned=0.
- lb addr 0x7 signed -> resp_rdata 0xFFFFFF88. lbu addr 0x7 -> 0x00000088. Each resp 3 cycles after acceptance.
- lh addr 0x6 signed -> 0xFFFF8877. lhu addr 0x4 -> 0x00006655.
- sb 0x000000AB to addr 0x5 -> read then single write, word 1 = 0x8877AB55. Follow-up lw addr 0x4 returns 0x8877AB55.
- lw addr 0x6 and sh addr 0x3 -> resp_misaligned=1, resp_rdata=0, mem_we never asserted, resp 1 cycle after acceptance.
- Assert rst during MERGE of sh 0x1234 to addr 0x8 -> mem_we low immediately, word 2 unchanged, no resp_valid, req_ready=1 after reset release. Request with addr 0x1004 (ADDR_WIDTH=10) wraps to word 1.
